// File: rtl/dsp_text_writer_if.sv
// Character-stream handshake and display write bus for dsp_text_writer.
// The master modport is the writer side: it consumes characters and drives the display.
interface dsp_text_writer_if;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        busy;
  logic [4:0]  dsp_row;
  logic [6:0]  dsp_col;
  logic        dsp_en;
  logic        dsp_wr;
  logic [15:0] dsp_wr_data;

  modport master (
    input  char_valid, char_data,
    output char_ready, busy, dsp_row, dsp_col, dsp_en, dsp_wr, dsp_wr_data
  );

  modport slave (
    output char_valid, char_data,
    input  char_ready, busy, dsp_row, dsp_col, dsp_en, dsp_wr, dsp_wr_data
  );
endinterface

// File: rtl/dsp_text_writer.sv
// Text writer for the character display: clears the screen, prints a banner,
// then places incoming characters at a wrapping hardware cursor.
module dsp_text_writer #(
  parameter int          ROWS    = 30,
  parameter int          COLS    = 80,
  parameter logic [7:0]  ATTR    = 8'h07,
  parameter logic [7:0]  BLANK   = 8'h20,
  parameter int          MSG_LEN = 12
) (
  input  logic clk,
  input  logic reset,
  dsp_text_writer_if.master bus
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_MSG   = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [6:0] LAST_MSG = 7'(MSG_LEN - 1);

  // Banner ROM: "Hello, world"
  function automatic logic [7:0] banner_byte(input logic [6:0] idx);
    logic [7:0] ch;
    case (idx)
      7'd0:    ch = 8'h48;
      7'd1:    ch = 8'h65;
      7'd2:    ch = 8'h6C;
      7'd3:    ch = 8'h6C;
      7'd4:    ch = 8'h6F;
      7'd5:    ch = 8'h2C;
      7'd6:    ch = 8'h20;
      7'd7:    ch = 8'h77;
      7'd8:    ch = 8'h6F;
      7'd9:    ch = 8'h72;
      7'd10:   ch = 8'h6C;
      7'd11:   ch = 8'h64;
      default: ch = BLANK;
    endcase
    return ch;
  endfunction

  state_t      state_r, state_s;
  logic [4:0]  row_r, row_s, adv_row_s, row_inc_s, wr_row_s;
  logic [6:0]  col_r, col_s, adv_col_s, wr_col_s;
  logic        banner_r, banner_s;
  logic        wr_s;
  logic [7:0]  wr_char_s;
  logic        accept_s;

  logic        char_ready_r;
  logic        busy_r;
  logic        dsp_en_r;
  logic        dsp_wr_r;
  logic [4:0]  dsp_row_r;
  logic [6:0]  dsp_col_r;
  logic [15:0] dsp_wr_data_r;

  // Cursor advance with explicit wrap at the last column and last row
  always_comb begin
    row_inc_s = (row_r == LAST_ROW) ? 5'd0 : row_r + 5'd1;
    if (col_r == LAST_COL) begin
      adv_col_s = 7'd0;
      adv_row_s = row_inc_s;
    end else begin
      adv_col_s = col_r + 7'd1;
      adv_row_s = row_r;
    end
  end

  // Next-state, cursor update and write request
  always_comb begin
    state_s   = state_r;
    row_s     = row_r;
    col_s     = col_r;
    banner_s  = banner_r;
    wr_s      = 1'b0;
    wr_char_s = BLANK;
    wr_row_s  = row_r;
    wr_col_s  = col_r;
    accept_s  = bus.char_valid & char_ready_r;
    case (state_r)
      ST_CLEAR: begin
        wr_s  = 1'b1;
        row_s = adv_row_s;
        col_s = adv_col_s;
        if ((row_r == LAST_ROW) && (col_r == LAST_COL)) begin
          row_s    = 5'd0;
          col_s    = 7'd0;
          banner_s = 1'b0;
          if (banner_r && (MSG_LEN > 0)) begin
            state_s = ST_MSG;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_MSG: begin
        // Row is still 0 from the clear, so col_r doubles as the ROM index
        wr_s      = 1'b1;
        wr_char_s = banner_byte(col_r);
        row_s     = adv_row_s;
        col_s     = adv_col_s;
        if (col_r == LAST_MSG) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_MSG;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          if (bus.char_data >= 8'h20) begin
            wr_s      = 1'b1;
            wr_char_s = bus.char_data;
            row_s     = adv_row_s;
            col_s     = adv_col_s;
          end else begin
            case (bus.char_data)
              8'h0A: begin
                col_s = 7'd0;
                row_s = row_inc_s;
              end
              8'h0D: begin
                col_s = 7'd0;
              end
              8'h0C: begin
                state_s = ST_CLEAR;
                row_s   = 5'd0;
                col_s   = 7'd0;
              end
              default: begin
                row_s = row_r;
                col_s = col_r;
              end
            endcase
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_CLEAR;
        row_s   = 5'd0;
        col_s   = 7'd0;
      end
    endcase
  end

  // State, cursor and banner-pending flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_CLEAR;
      row_r    <= 5'd0;
      col_r    <= 7'd0;
      banner_r <= 1'b1;
    end else begin
      state_r  <= state_s;
      row_r    <= row_s;
      col_r    <= col_s;
      banner_r <= banner_s;
    end
  end

  // Registered handshake, status and display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_ready_r  <= 1'b0;
      busy_r        <= 1'b1;
      dsp_en_r      <= 1'b0;
      dsp_wr_r      <= 1'b0;
      dsp_row_r     <= 5'd0;
      dsp_col_r     <= 7'd0;
      dsp_wr_data_r <= 16'd0;
    end else begin
      char_ready_r <= (state_s == ST_RUN);
      busy_r       <= (state_s != ST_RUN);
      dsp_en_r     <= wr_s;
      dsp_wr_r     <= wr_s;
      if (wr_s) begin
        dsp_row_r     <= wr_row_s;
        dsp_col_r     <= wr_col_s;
        dsp_wr_data_r <= {ATTR, wr_char_s};
      end else begin
        dsp_row_r     <= dsp_row_r;
        dsp_col_r     <= dsp_col_r;
        dsp_wr_data_r <= dsp_wr_data_r;
      end
    end
  end

  assign bus.char_ready  = char_ready_r;
  assign bus.busy        = busy_r;
  assign bus.dsp_en      = dsp_en_r;
  assign bus.dsp_wr      = dsp_wr_r;
  assign bus.dsp_row     = dsp_row_r;
  assign bus.dsp_col     = dsp_col_r;
  assign bus.dsp_wr_data = dsp_wr_data_r;

endmodule

// File: tb/tb_dsp_text_writer.sv
// Self-checking bench for dsp_text_writer: clear/banner sequences, cursor wrap,
// control codes, form-feed re-clear, mid-clear reset and random character traffic.
module tb_dsp_text_writer;
  localparam int         ROWS = 30;
  localparam int         COLS = 80;
  localparam logic [7:0] ATTR = 8'h07;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dsp_text_writer_if bus();
  dsp_text_writer dut (.clk(clk), .reset(reset), .bus(bus));

  int    errors = 0;
  int    checks = 0;
  int    mrow, mcol;
  string banner = "Hello, world";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {2'b00, bus.dsp_en, bus.dsp_wr, bus.dsp_row, bus.dsp_col, bus.dsp_wr_data};
  endfunction

  function automatic logic [31:0] strobe_word(input int r, input int c, input logic [7:0] ch);
    return {2'b00, 2'b11, 5'(r), 7'(c), ATTR, ch};
  endfunction

  // Reference cursor: returns whether the character writes, and where
  task automatic model_apply(input logic [7:0] b, output bit w, output int r, output int c);
    w = 1'b0;
    r = mrow;
    c = mcol;
    if (b >= 8'h20) begin
      w = 1'b1;
      mcol = mcol + 1;
      if (mcol == COLS) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
      end
    end else if (b == 8'h0A) begin
      mcol = 0;
      mrow = (mrow + 1) % ROWS;
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0C) begin
      mrow = 0;
      mcol = 0;
    end
  endtask

  task automatic check_reset();
    check("rst_out", obs(), 32'd0);
    check("rst_ready", {31'd0, bus.char_ready}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic run_clear(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (obs() !== strobe_word(i / COLS, i % COLS, 8'h20)) bad++;
    end
    check("clear_cells", bad, 32'd0);
  endtask

  task automatic expect_banner();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("banner", obs(), strobe_word(0, i, banner[i]));
    end
    mrow = 0;
    mcol = 12;
    @(negedge clk);
    check("banner_done", {29'd0, bus.busy, bus.char_ready, bus.dsp_en}, 32'b010);
  endtask

  // Called at a negedge; leaves char_valid high so calls chain back-to-back
  task automatic send_char(input logic [7:0] b);
    int waited = 0;
    bit w;
    int r, c;
    while (!bus.char_ready && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.char_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.char_valid = 1'b1;
    bus.char_data  = b;
    @(negedge clk);
    model_apply(b, w, r, c);
    if (w) check("write", obs(), strobe_word(r, c, b));
    else   check("nowrite", {30'd0, bus.dsp_en, bus.dsp_wr}, 32'd0);
  endtask

  task automatic idle(input int n);
    bus.char_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle", {31'd0, bus.dsp_en}, 32'd0);
    end
  endtask

  task automatic goto_cell(input int r, input int c);
    send_char(8'h0D);
    while (mrow != r) send_char(8'h0A);
    repeat (c) send_char(8'h2E);
  endtask

  initial begin
    logic [7:0] b;
    int         sel;
    reset          = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    mrow = 0;
    mcol = 0;
    repeat (3) @(negedge clk);
    check_reset();
    reset = 1'b1;
    run_clear(ROWS * COLS);
    expect_banner();

    send_char(8'h41);
    send_char(8'h42);
    idle(1);

    goto_cell(0, 79);
    send_char(8'h58);
    send_char(8'h59);
    goto_cell(29, 79);
    send_char(8'h5A);
    send_char(8'h51);
    idle(1);

    goto_cell(3, 5);
    send_char(8'h0A);
    send_char(8'h61);
    send_char(8'h0D);
    send_char(8'h62);
    send_char(8'h07);
    idle(2);

    // Form feed with a character held valid across the whole re-clear
    send_char(8'h0C);
    check("ff_ready", {31'd0, bus.char_ready}, 32'd0);
    bus.char_data = 8'h43;
    run_clear(ROWS * COLS);
    send_char(8'h43);
    idle(1);

    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 19);
      if (sel == 14 || sel == 15) begin
        b = 8'h0A;
      end else if (sel == 16) begin
        b = 8'h0D;
      end else if (sel == 17) begin
        b = 8'($urandom_range(0, 31));
        while (b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'($urandom_range(0, 31));
      end else begin
        b = 8'($urandom_range(32, 255));
      end
      send_char(b);
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
    end

    // Reset during the 1000th strobe of a re-clear
    send_char(8'h0C);
    bus.char_valid = 1'b0;
    run_clear(999);
    @(negedge clk);
    check("clear_1000", obs(), strobe_word(999 / COLS, 999 % COLS, 8'h20));
    reset = 1'b0;
    #1;
    check_reset();
    mrow = 0;
    mcol = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_clear(ROWS * COLS);
    expect_banner();
    send_char(8'h4F);
    send_char(8'h4B);
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dsp_text_writer.md
Name: dsp_text_writer

Overview:
Write-side initiator for the character display controller's write port (dsp_row/dsp_col/dsp_en/dsp_wr/dsp_wr_data). After reset it clears the whole text screen and prints a fixed banner from an internal ROM. It then accepts a stream of 8-bit characters over a valid/ready handshake and places them at a hardware cursor. It sits between any character source (UART receiver, CPU port, test logic) and the display controller instance.

Parameters:
ROWS, 30, number of text rows; 1..32, must fit dsp_row.
COLS, 80, number of text columns; 1..128, must fit dsp_col.
ATTR, 8'h07, attribute byte placed in dsp_wr_data[15:8] for every write.
BLANK, 8'h20, character code written during screen clear.
MSG_LEN, 12, banner length in characters. Banner ROM contents are "Hello, world"; MSG_LEN must be <= COLS.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
char_valid  input  1  source presents a character on char_data.
char_data  input  8  character code.
char_ready  output  1  writer can accept a character this cycle.
busy  output  1  high while a clear or banner sequence is in progress.
dsp_row  output  5  display write row.
dsp_col  output  7  display write column.
dsp_en  output  1  display access enable.
dsp_wr  output  1  display write strobe.
dsp_wr_data  output  16  {ATTR, char}.

Behaviour:
- Reset (reset=0, asynchronous): state=CLEAR, cursor (row,col)=(0,0), dsp_en=0, dsp_wr=0, dsp_row=0, dsp_col=0, dsp_wr_data=0, char_ready=0, busy=1.
- All dsp_* outputs are registered. dsp_en and dsp_wr are always asserted together for exactly one cycle per write. A cell write completes in the cycle the strobe is high; there is no back-pressure from the display.
- CLEAR:
  - One write per cycle of {ATTR,BLANK}, in row-major order from (0,0) to (ROWS-1,COLS-1).
  - That is ROWS*COLS strobes on consecutive cycles: 2400 with the defaults.
  - After the last cell, go to MSG if entered from reset, otherwise to RUN.
  - Cursor is set to (0,0).
- MSG:
  - One write per cycle of banner ROM byte i at (0,i), for i=0..MSG_LEN-1.
  - Then set cursor to (0,MSG_LEN); if MSG_LEN==COLS, set it to (1,0).
  - Go to RUN.
- RUN: busy=0, char_ready=1. A character is accepted on a clock edge where char_valid and char_ready are both high. Its effect appears on dsp_* in the following cycle. Back-to-back accepts are allowed, one per cycle.
  - Printable (0x20..0xFF): write {ATTR,char} at the cursor, then advance the cursor.
  - Advance rule: col+1. If col==COLS-1, set col=0 and row+1. If row==ROWS-1, row wraps to 0. There is no scrolling.
  - 0x0A (newline): no write. Set col=0 and row+1, with the same wrap.
  - 0x0D (carriage return): no write. Set col=0.
  - 0x0C (form feed): no write. Drop char_ready the next cycle and enter CLEAR (re-clear, no banner). Cursor ends at (0,0).
  - Any other code below 0x20: accepted, no write, cursor unchanged.
- char_ready is 0 in CLEAR and MSG. Characters presented then are held by the source, never dropped.
- Reset asserted mid-sequence: the sequence is aborted immediately and restarts from CLEAR at (0,0) after release.
- Counter widths: row counter 5 bits, col counter 7 bits. Comparisons use ROWS-1 and COLS-1, never natural overflow.

Test Plan:
1. Release reset, hold char_valid=0 -> exactly 2400 consecutive strobes of 16'h0720 covering (0,0)..(29,79) once each. Then 12 strobes of 16'h0748 ('H')...16'h0764 ('d') at (0,0)..(0,11). Then busy=0, char_ready=1.
2. In RUN, send 'A','B' on consecutive cycles -> strobes of 16'h0741 at (0,12) and 16'h0742 at (0,13) on consecutive cycles, each one cycle after acceptance.
3. Cursor at (0,79), send 'X' then 'Y' -> 'X' written at (0,79), 'Y' at (1,0). Cursor at (29,79), send 'Z' then 'Q' -> 'Q' written at (0,0).
4. Send 0x0A at (3,5), then 'a' -> no strobe for 0x0A; 16'h0761 at (4,0). Send 0x0D at (4,1), then 'b' -> 16'h0762 at (4,0). Send 0x07 -> accepted, no strobe.
5. Send 0x0C -> char_ready low, 2400 blank strobes, no banner, then 'C' written at (0,0). A char_valid held throughout the clear is accepted only after ready returns.
6. Assert reset during the 1000th clear strobe -> all outputs go to their reset values immediately. After release, the full clear restarts from (0,0).
